// File: rtl/pci_pkg.sv
// ---------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI target and master: bus command codes, FSM
// state encoding, and a byte-lane merge helper used by the target memory.
// ---------------------------------------------------------------------------
package pci_pkg;

    // Bus commands claimed by the target (driven on cbe_n in the address phase)
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    // Target FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BUS_BUSY = 3'd1;
    localparam logic [2:0] ST_RD_TA    = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Replace the byte lanes of old_word whose active-low enable is 0
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be_n);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < 4; k++) begin
            if (!be_n[k]) result[8*k +: 8] = new_word[8*k +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/pci_target_mem.sv
// ---------------------------------------------------------------------------
// pci_target_mem
// DEPTH x 32-bit word store for the PCI target. Cleared asynchronously by
// rst_n, byte-enabled synchronous write port, combinational read port.
//
// Ports:
//   clk, rst_n   clock / async active-low clear
//   i_we         write strobe (one word per clock)
//   i_be_n       active-low byte enables for the write
//   i_widx       write word index
//   i_wdata      write data
//   i_ridx       read word index
//   o_rdata      read data (combinational)
// ---------------------------------------------------------------------------
module pci_target_mem
    import pci_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [3:0]    i_be_n,
    input  logic [IW-1:0] i_widx,
    input  logic [31:0]   i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (i_we) begin
            r_mem[i_widx] <= merge_bytes(r_mem[i_widx], i_wdata, i_be_n);
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/pci_target.sv
// ---------------------------------------------------------------------------
// pci_target
// Memory-mapped PCI target. Claims memory read/write commands that hit the
// DEPTH-word window at BASE_ADDR and serves single or linear-burst transfers
// from an internal word array. All bus outputs are registered.
//
// Handshake: a data phase transfers on a rising edge where irdy_n and trdy_n
// are both low; frame_n high at such an edge marks the final phase. With
// irdy_n high in a data state nothing moves (index, read data, trdy_n held).
//
// Ports:
//   clk, rst_n   bus clock / async active-low reset
//   frame_n      initiator FRAME#
//   irdy_n       initiator IRDY#
//   cbe_n        command (address phase) / active-low byte enables (data)
//   ad_i         address/data from the bus
//   ad_o, ad_oe  read data to the bus and its drive enable
//   trdy_n       target TRDY#
//   devsel_n     target DEVSEL#
// ---------------------------------------------------------------------------
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_i,
    output logic [31:0] ad_o,
    output logic        ad_oe,
    output logic        trdy_n,
    output logic        devsel_n
);

    localparam int IW = $clog2(DEPTH);

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_ad_o;
    logic          r_ad_oe;
    logic          r_trdy_n;
    logic          r_devsel_n;

    logic          w_hit;
    logic [IW-1:0] w_addr_idx;
    logic [IW-1:0] w_idx_next;
    logic [IW-1:0] w_ridx;
    logic [31:0]   w_rdata;
    logic          w_xfer;
    logic          w_wr_en;
    logic          w_unused;

    // Address bits [1:0] play no part in a linear burst
    assign w_unused   = &{1'b0, ad_i[1:0]};

    assign w_hit      = (ad_i[31:IW+2] == BASE_ADDR[31:IW+2]);
    assign w_addr_idx = ad_i[IW+1:2];
    // Power-of-two DEPTH: the natural overflow gives the wrap to word 0
    assign w_idx_next = r_idx + 1'b1;
    assign w_xfer     = !irdy_n && !r_trdy_n;
    assign w_wr_en    = (r_state == ST_WR_DATA) && w_xfer;
    // In RD_DATA the word fetched is the one after the word on the bus
    assign w_ridx     = (r_state == ST_RD_DATA) ? w_idx_next : r_idx;

    pci_target_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_en),
        .i_be_n  (cbe_n),
        .i_widx  (r_idx),
        .i_wdata (ad_i),
        .i_ridx  (w_ridx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_ad_o     <= '0;
            r_ad_oe    <= 1'b0;
            r_trdy_n   <= 1'b1;
            r_devsel_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!frame_n) begin
                        if (w_hit && cbe_n == CMD_MEM_RD) begin
                            r_idx      <= w_addr_idx;
                            r_devsel_n <= 1'b0;
                            r_state    <= ST_RD_TA;
                        end else if (w_hit && cbe_n == CMD_MEM_WR) begin
                            r_idx      <= w_addr_idx;
                            r_devsel_n <= 1'b0;
                            r_trdy_n   <= 1'b0;
                            r_state    <= ST_WR_DATA;
                        end else begin
                            r_state    <= ST_BUS_BUSY;
                        end
                    end
                end
                ST_BUS_BUSY: begin
                    if (frame_n && irdy_n) r_state <= ST_IDLE;
                end
                ST_RD_TA: begin
                    // Turnaround ends: start driving the first word
                    r_ad_o   <= w_rdata;
                    r_ad_oe  <= 1'b1;
                    r_trdy_n <= 1'b0;
                    r_state  <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (w_xfer) begin
                        r_idx  <= w_idx_next;
                        r_ad_o <= w_rdata;
                        if (frame_n) begin
                            r_ad_oe    <= 1'b0;
                            r_trdy_n   <= 1'b1;
                            r_devsel_n <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_xfer) begin
                        r_idx <= w_idx_next;
                        if (frame_n) begin
                            r_trdy_n   <= 1'b1;
                            r_devsel_n <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ad_oe    <= 1'b0;
                    r_trdy_n   <= 1'b1;
                    r_devsel_n <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ad_o     = r_ad_o;
    assign ad_oe    = r_ad_oe;
    assign trdy_n   = r_trdy_n;
    assign devsel_n = r_devsel_n;

endmodule

// File: tb/tb_pci_target.sv
// ---------------------------------------------------------------------------
// tb_pci_target
// Bench for pci_target: a simple initiator drives transactions, a word-array
// model tracks memory contents, and read data is checked from an expected
// queue. Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_pci_target;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;
    localparam logic [3:0]  C_RD  = 4'b0110;
    localparam logic [3:0]  C_WR  = 4'b0111;

    logic        clk;
    logic        rst_n;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad_i;
    logic [31:0] ad_o;
    logic        ad_oe;
    logic        trdy_n;
    logic        devsel_n;

    int n_cmp;
    int n_err;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] wd  [16];
    logic [3:0]  wbe [16];

    pci_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .cbe_n    (cbe_n),
        .ad_i     (ad_i),
        .ad_o     (ad_o),
        .ad_oe    (ad_oe),
        .trdy_n   (trdy_n),
        .devsel_n (devsel_n)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] d,
                                             input logic [3:0]  be_n);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (!be_n[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = 4'hF;
        ad_i    = '0;
    endtask

    // Write burst of n words from wd/wbe with up to max_wait initiator waits
    task automatic bus_write(input logic [31:0] addr, input int n, input int max_wait);
        int idx;
        int w;
        idx = word_of(addr);
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = C_WR; ad_i = addr;
        tick();
        n_cmp++;
        if (devsel_n !== 1'b0 || trdy_n !== 1'b0) begin
            n_err++;
            $display("FAIL wr_claim: devsel_n=%b trdy_n=%b exp 0/0", devsel_n, trdy_n);
        end
        for (int i = 0; i < n; i++) begin
            w = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            repeat (w) begin
                irdy_n = 1'b1; ad_i = $urandom; cbe_n = 4'($urandom);
                tick();
            end
            irdy_n = 1'b0; ad_i = wd[i]; cbe_n = wbe[i]; frame_n = (i == n - 1);
            n_cmp++;
            if (trdy_n !== 1'b0) begin
                n_err++;
                $display("FAIL wr_trdy: word %0d trdy_n=%b exp 0", i, trdy_n);
            end
            tick();
            model_mem[idx] = apply_be(model_mem[idx], wd[i], wbe[i]);
            idx = (idx + 1) % DEPTH;
        end
        bus_idle();
        n_cmp++;
        if (devsel_n !== 1'b1 || trdy_n !== 1'b1 || ad_oe !== 1'b0) begin
            n_err++;
            $display("FAIL wr_done: devsel_n=%b trdy_n=%b ad_oe=%b exp 1/1/0",
                     devsel_n, trdy_n, ad_oe);
        end
        tick();
    endtask

    // Read burst of n words, checking against the model via exp_q
    task automatic bus_read(input logic [31:0] addr, input int n, input int max_wait);
        int idx;
        int w;
        idx = word_of(addr);
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(idx + i) % DEPTH]);
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = C_RD; ad_i = addr;
        tick();
        n_cmp++;
        if (devsel_n !== 1'b0 || trdy_n !== 1'b1 || ad_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rd_turnaround: devsel_n=%b trdy_n=%b ad_oe=%b exp 0/1/0",
                     devsel_n, trdy_n, ad_oe);
        end
        cbe_n = 4'h0; ad_i = '0;
        tick();
        for (int i = 0; i < n; i++) begin
            w = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            repeat (w) begin
                irdy_n = 1'b1;
                n_cmp++;
                if (ad_o !== exp_q[0] || trdy_n !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd_wait_hold: ad_o=%h trdy_n=%b exp %h/0",
                             ad_o, trdy_n, exp_q[0]);
                end
                tick();
            end
            irdy_n = 1'b0; frame_n = (i == n - 1);
            n_cmp++;
            if (ad_oe !== 1'b1 || trdy_n !== 1'b0 || ad_o !== exp_q[0]) begin
                n_err++;
                $display("FAIL rd_data: word %0d ad_o=%h ad_oe=%b trdy_n=%b exp %h/1/0",
                         i, ad_o, ad_oe, trdy_n, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        bus_idle();
        n_cmp++;
        if (devsel_n !== 1'b1 || trdy_n !== 1'b1 || ad_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rd_done: devsel_n=%b trdy_n=%b ad_oe=%b exp 1/1/0",
                     devsel_n, trdy_n, ad_oe);
        end
        tick();
    endtask

    // Transaction the target must not claim
    task automatic bus_ignored(input logic [31:0] addr, input logic [3:0] cmd, input int ncyc);
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = cmd; ad_i = addr;
        tick();
        for (int i = 0; i <= ncyc; i++) begin
            if (i == ncyc) begin
                frame_n = 1'b1; irdy_n = 1'b1;
            end else begin
                frame_n = (i == ncyc - 1); irdy_n = 1'b0;
            end
            ad_i = $urandom; cbe_n = 4'($urandom);
            n_cmp++;
            if (devsel_n !== 1'b1 || trdy_n !== 1'b1 || ad_oe !== 1'b0) begin
                n_err++;
                $display("FAIL ignore: addr=%h cmd=%b devsel_n=%b trdy_n=%b ad_oe=%b exp 1/1/0",
                         addr, cmd, devsel_n, trdy_n, ad_oe);
            end
            tick();
        end
        bus_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_idle();
        rst_n = 1'b0;
        clear_model();
        tick(); tick();
        n_cmp++;
        if (devsel_n !== 1'b1 || trdy_n !== 1'b1 || ad_oe !== 1'b0 || ad_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: devsel_n=%b trdy_n=%b ad_oe=%b ad_o=%h exp 1/1/0/0",
                     devsel_n, trdy_n, ad_oe, ad_o);
        end
        rst_n = 1'b1;
        tick();
        bus_read(BASE, DEPTH, 0);
    endtask

    task automatic test_single_write();
        wd[0] = 32'hDEAD_BEEF; wbe[0] = 4'b0000;
        bus_write(32'h0000_1008, 1, 0);
        bus_read(32'h0000_1008, 1, 0);
    endtask

    task automatic test_read_burst();
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        wbe[0] = 4'h0; wbe[1] = 4'h0; wbe[2] = 4'h0;
        bus_write(32'h0000_1004, 3, 0);
        bus_read(32'h0000_1004, 3, 0);
    endtask

    task automatic test_byte_enable();
        wd[0] = 32'h1234_5678; wbe[0] = 4'b0000;
        bus_write(32'h0000_1014, 1, 0);
        wd[0] = 32'hAABB_CCDD; wbe[0] = 4'b1010;
        bus_write(32'h0000_1014, 1, 0);
        n_cmp++;
        if (model_mem[5] !== 32'h12BB_56DD) begin
            n_err++;
            $display("FAIL be_model: model=%h exp 12bb56dd", model_mem[5]);
        end
        bus_read(32'h0000_1014, 1, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            wd[i] = $urandom; wbe[i] = 4'h0;
        end
        bus_write(32'h0000_101C, 3, 0);
        bus_read(BASE, DEPTH, 0);
        bus_read(32'h0000_101C, 3, 0);
    endtask

    task automatic test_ignored();
        bus_ignored(32'h0000_2000, C_RD, 3);
        bus_ignored(32'h0000_1000, 4'b0010, 3);
        bus_ignored(32'h0000_2004, C_WR, 2);
        bus_read(BASE, DEPTH, 0);
    endtask

    task automatic test_back_to_back();
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = C_WR; ad_i = BASE;
        tick();
        frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_i = 32'hCAFE_0001;
        tick();
        model_mem[0] = 32'hCAFE_0001;
        // Address phase presented during DONE: not an address phase yet
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = C_RD; ad_i = BASE;
        n_cmp++;
        if (devsel_n !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done: devsel_n=%b exp 1", devsel_n);
        end
        tick();
        n_cmp++;
        if (devsel_n !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ignored_in_done: devsel_n=%b exp 1", devsel_n);
        end
        tick();
        n_cmp++;
        if (devsel_n !== 1'b0 || trdy_n !== 1'b1 || ad_oe !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_claim: devsel_n=%b trdy_n=%b ad_oe=%b exp 0/1/0",
                     devsel_n, trdy_n, ad_oe);
        end
        frame_n = 1'b1; irdy_n = 1'b0;
        tick();
        n_cmp++;
        if (ad_o !== model_mem[0] || ad_oe !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_data: ad_o=%h ad_oe=%b exp %h/1", ad_o, ad_oe, model_mem[0]);
        end
        tick();
        bus_idle();
        tick();
    endtask

    task automatic test_wait_and_reset();
        logic [31:0] held;
        frame_n = 1'b0; irdy_n = 1'b1; cbe_n = C_RD; ad_i = BASE;
        tick();
        tick();
        irdy_n = 1'b0;
        tick();
        held = model_mem[1];
        irdy_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ad_o !== held || trdy_n !== 1'b0 || ad_oe !== 1'b1) begin
                n_err++;
                $display("FAIL wait_hold: ad_o=%h trdy_n=%b ad_oe=%b exp %h/0/1",
                         ad_o, trdy_n, ad_oe, held);
            end
            tick();
        end
        irdy_n = 1'b0;
        n_cmp++;
        if (ad_o !== held) begin
            n_err++;
            $display("FAIL wait_no_advance: ad_o=%h exp %h", ad_o, held);
        end
        tick();
        n_cmp++;
        if (ad_o !== model_mem[2]) begin
            n_err++;
            $display("FAIL wait_resume: ad_o=%h exp %h", ad_o, model_mem[2]);
        end
        // Reset in the middle of the burst, well away from any clock edge
        rst_n = 1'b0;
        #5;
        n_cmp++;
        if (devsel_n !== 1'b1 || trdy_n !== 1'b1 || ad_oe !== 1'b0 || ad_o !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: devsel_n=%b trdy_n=%b ad_oe=%b ad_o=%h exp 1/1/0/0",
                     devsel_n, trdy_n, ad_oe, ad_o);
        end
        clear_model();
        bus_idle();
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(BASE, DEPTH, 0);
    endtask

    task automatic test_random();
        int op;
        int len;
        int start;
        logic [31:0] addr;
        logic [3:0]  cmd;
        for (int t = 0; t < 40; t++) begin
            op    = int'($urandom_range(0, 4));
            len   = int'($urandom_range(1, 6));
            start = int'($urandom_range(0, DEPTH - 1));
            addr  = BASE + 32'(start * 4) + 32'($urandom_range(0, 3));
            if (op <= 1) begin
                for (int i = 0; i < len; i++) begin
                    wd[i] = $urandom; wbe[i] = 4'($urandom);
                end
                bus_write(addr, len, 2);
            end else if (op <= 3) begin
                bus_read(addr, len, 2);
            end else if ($urandom_range(0, 1) == 0) begin
                addr = BASE + 32'(DEPTH * 4 * int'($urandom_range(1, 20)));
                bus_ignored(addr, ($urandom_range(0, 1) == 0) ? C_RD : C_WR, len);
            end else begin
                cmd = 4'($urandom_range(0, 15));
                while (cmd == C_RD || cmd == C_WR) cmd = 4'($urandom_range(0, 15));
                bus_ignored(addr, cmd, len);
            end
        end
        bus_read(BASE, DEPTH, 0);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_byte_enable();
        test_wrap();
        test_ignored();
        test_back_to_back();
        test_random();
        test_wait_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
